// File: rtl/shared_reg_arb_pkg.sv
// rtl/shared_reg_arb_pkg.sv - shared types, constants and round-robin helper for shared_reg_arbiter
// Purpose : FSM state type, default data width and the round-robin search
//           function used by rr_picker.
// Ports   : none (package)
// Config  : SHARED_REG_ARB_PARITY_EN is not used here.
package shared_reg_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    // Default shared register width (2 * default WIDTH of 32).
    localparam int DW = 64;

    // Widest requester vector the helper is sized for.
    localparam int MAX_REQ = 8;

    // Returns the first set request scanning last+1, last+2, ... modulo n.
    // When nothing is requested the result is 'last'; callers gate with |req.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [2:0]         last,
                                           input int                 n);
        logic [2:0] sel;
        logic       found;
        int         idx;
        logic [2:0] idx3;
        sel   = last;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx  = (int'(last) + k) % n;
            idx3 = idx[2:0];
            if (k <= n && !found && req[idx3]) begin
                sel   = idx3;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// rtl/shared_reg_arbiter_if.sv - requester/output bus bundle for shared_reg_arbiter
// Purpose : groups the per-requester request side and the shared register side.
// Ports   : req, lock, wdata (requesters -> arbiter);
//           gnt, q, q_valid, owner, busy (arbiter -> requesters/output bus);
//           q_par (arbiter -> output bus, only with SHARED_REG_ARB_PARITY_EN).
// Modports: slave = arbiter side, master = requester/bench side.
interface shared_reg_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
);
    localparam int DWL = 2 * WIDTH;
    localparam int OW  = $clog2(NREQ);

    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     lock;
    logic [NREQ*DWL-1:0] wdata;
    logic [NREQ-1:0]     gnt;
    logic [DWL-1:0]      q;
    logic                q_valid;
    logic [OW-1:0]       owner;
    logic                busy;
`ifdef SHARED_REG_ARB_PARITY_EN
    logic                q_par;
`endif

    modport slave (
        input  req, lock, wdata,
`ifdef SHARED_REG_ARB_PARITY_EN
        output q_par,
`endif
        output gnt, q, q_valid, owner, busy
    );

    modport master (
        output req, lock, wdata,
`ifdef SHARED_REG_ARB_PARITY_EN
        input  q_par,
`endif
        input  gnt, q, q_valid, owner, busy
    );

endinterface

// File: rtl/shared_reg_arbiter_rr_picker.sv
// rtl/shared_reg_arbiter_rr_picker.sv - combinational round-robin search
// Purpose : selects the next requester after 'last' with wrap-around.
// Ports   : req  in  NREQ   request vector
//           last in  OW     index of the previous owner
//           sel  out OW     chosen index (valid when any=1)
//           any  out 1      at least one request present
module rr_picker
    import shared_reg_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int OW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [OW-1:0]   last,
    output logic [OW-1:0]   sel,
    output logic            any
);
    logic [MAX_REQ-1:0] reqExt;
    logic [2:0]         lastExt;
    logic [2:0]         pick;

    assign reqExt  = MAX_REQ'(req);
    assign lastExt = 3'(last);
    assign pick    = rr_pick(reqExt, lastExt, NREQ);
    assign sel     = pick[OW-1:0];
    assign any     = |req;

endmodule

// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin owner of a shared 2*WIDTH-bit output register
// Purpose : grants one requester at a time, latches its write data into the
//           shared register, holds ownership across locked bursts up to
//           HOLD_MAX beats, then releases with one dead cycle before the
//           next grant.
// Ports   : clk  in  clock
//           rst  in  synchronous active-high reset
//           bus  slave modport of shared_reg_arbiter_if
//                (req, lock, wdata in; gnt, q, q_valid, owner, busy out)
// Config  : SHARED_REG_ARB_PARITY_EN adds bus.q_par = ^wdata[owner],
//           registered alongside q.
module shared_reg_arbiter
    import shared_reg_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 32,
    parameter int HOLD_MAX = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    shared_reg_arbiter_if.slave  bus
);
    localparam int DWL = 2 * WIDTH;
    localparam int OW  = $clog2(NREQ);

    localparam logic [0:0] stIdle  = IDLE;
    localparam logic [0:0] stOwn   = OWN;
    localparam logic [7:0] holdLim = 8'(HOLD_MAX);

    logic [0:0]      state;
    logic [7:0]      beatCnt;
    logic [7:0]      beatNext;
    logic [OW-1:0]   ownerR;
    logic [NREQ-1:0] gntR;
    logic [DWL-1:0]  qR;
    logic            qValidR;
    logic [DWL-1:0]  ownerData;
    logic            ownerReq;
    logic            ownerLock;
    logic [OW-1:0]   pickSel;
    logic            pickAny;
`ifdef SHARED_REG_ARB_PARITY_EN
    logic            qParR;
`endif

    rr_picker #(.NREQ(NREQ), .OW(OW)) uPicker (
        .req  (bus.req),
        .last (ownerR),
        .sel  (pickSel),
        .any  (pickAny)
    );

    assign ownerData = bus.wdata[int'(ownerR)*DWL +: DWL];
    assign ownerReq  = bus.req[ownerR];
    assign ownerLock = bus.lock[ownerR];
    assign beatNext  = beatCnt + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= stIdle;
            beatCnt <= '0;
            ownerR  <= OW'(NREQ - 1);
            gntR    <= '0;
            qR      <= '0;
            qValidR <= 1'b0;
`ifdef SHARED_REG_ARB_PARITY_EN
            qParR   <= 1'b0;
`endif
        end else begin
            qValidR <= 1'b0;
            case (state)
                stIdle: begin
                    beatCnt <= '0;
                    if (pickAny) begin
                        gntR   <= NREQ'(1) << pickSel;
                        ownerR <= pickSel;
                        state  <= stOwn;
                    end else begin
                        gntR <= '0;
                    end
                end
                default: begin
                    if (ownerReq) begin
                        qR      <= ownerData;
                        qValidR <= 1'b1;
                        beatCnt <= beatNext;
`ifdef SHARED_REG_ARB_PARITY_EN
                        qParR   <= ^ownerData;
`endif
                        // Keep the bus only while locked and under the beat cap;
                        // the cap check uses the post-increment count.
                        if (!(ownerLock && (beatNext < holdLim))) begin
                            gntR  <= '0;
                            state <= stIdle;
                        end
                    end else begin
                        // Owner withdrew: release without touching q.
                        gntR  <= '0;
                        state <= stIdle;
                    end
                end
            endcase
        end
    end

    assign bus.gnt     = gntR;
    assign bus.q       = qR;
    assign bus.q_valid = qValidR;
    assign bus.owner   = ownerR;
    assign bus.busy    = (state == stOwn);
`ifdef SHARED_REG_ARB_PARITY_EN
    assign bus.q_par   = qParR;
`endif

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb/tb_shared_reg_arbiter.sv - scoreboard bench for shared_reg_arbiter
module tb_shared_reg_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shared_reg_arbiter_if #(.NREQ(4), .WIDTH(32)) bus ();

    shared_reg_arbiter #(.NREQ(4), .WIDTH(32), .HOLD_MAX(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] data;
        int          own;
    } beat_t;

    beat_t      expQ[$];
    int         expGnt[$];
    logic [3:0] prevGnt = 4'b0000;
    int         nChecks = 0;
    int         nErrors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pushBeat(input logic [63:0] d, input int o);
        beat_t b;
        b.data = d;
        b.own  = o;
        expQ.push_back(b);
    endtask

    task automatic setW(input int i, input logic [63:0] d);
        bus.wdata[i*64 +: 64] = d;
    endtask

    // Monitor: compares every new grant and every q_valid beat to the queues.
    always @(negedge clk) begin
        if (bus.gnt !== 4'b0000 && prevGnt === 4'b0000) begin
            if (expGnt.size() == 0) begin
                chk("unexpected grant", 64'(bus.gnt), 64'h0);
            end else begin
                int e;
                e = expGnt.pop_front();
                chk("grant order", 64'(bus.gnt), 64'(4'b0001 << e));
                chk("grant owner", 64'(bus.owner), 64'(e));
            end
        end
        prevGnt <= bus.gnt;
        if (bus.q_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                chk("unexpected q_valid", bus.q, 64'h0);
            end else begin
                beat_t b;
                b = expQ.pop_front();
                chk("beat q", bus.q, b.data);
                chk("beat owner", 64'(bus.owner), 64'(b.own));
`ifdef SHARED_REG_ARB_PARITY_EN
                chk("beat q_par", 64'(bus.q_par), 64'(^b.data));
`endif
            end
        end
    end

    logic [3:0]  pat2[10];
    logic [63:0] d2[4];

    initial begin
        pat2 = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
        d2   = '{64'h0000_0000_0000_00A0, 64'h0000_0000_0000_00A1,
                 64'h0000_0000_0000_00A2, 64'h0000_0000_0000_00A3};
        rst       = 1'b1;
        bus.req   = '0;
        bus.lock  = '0;
        bus.wdata = '0;
        step();
        step();
        chk("reset gnt", 64'(bus.gnt), 64'h0);
        chk("reset q", bus.q, 64'h0);
        chk("reset q_valid", 64'(bus.q_valid), 64'h0);
        chk("reset owner", 64'(bus.owner), 64'd3);
        chk("reset busy", 64'(bus.busy), 64'h0);
        rst = 1'b0;

        // 1: single unlocked beat from requester 0
        setW(0, 64'hDEAD_BEEF_0000_0001);
        bus.req = 4'b0001;
        expGnt.push_back(0);
        pushBeat(64'hDEAD_BEEF_0000_0001, 0);
        step();
        chk("t1 gnt", 64'(bus.gnt), 64'h1);
        chk("t1 busy", 64'(bus.busy), 64'h1);
        step();
        chk("t1 q", bus.q, 64'hDEAD_BEEF_0000_0001);
        chk("t1 q_valid", 64'(bus.q_valid), 64'h1);
        chk("t1 busy falls", 64'(bus.busy), 64'h0);
        bus.req = 4'b0000;
        step();
        chk("t1 q_valid pulse", 64'(bus.q_valid), 64'h0);
        chk("t1 q hold", bus.q, 64'hDEAD_BEEF_0000_0001);

        // 2: all requesting, unlocked -> 0,1,2,3,0 with idle gaps
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) setW(i, d2[i]);
        for (int i = 0; i < 5; i++) begin
            expGnt.push_back(i % 4);
            pushBeat(d2[i % 4], i % 4);
        end
        bus.req = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("t2 gnt c%0d", c), 64'(bus.gnt), 64'(pat2[c]));
        end
        bus.req = 4'b0000;

        // 3: locked burst capped at 15 beats, then pending req1 wins
        rst = 1'b1;
        step();
        rst = 1'b0;
        setW(0, 64'h5A5A_5A5A_5A5A_5A5A);
        setW(1, 64'hB1B1_B1B1_0000_0001);
        expGnt.push_back(0);
        for (int i = 0; i < 15; i++) pushBeat(64'h5A5A_5A5A_5A5A_5A5A, 0);
        expGnt.push_back(1);
        pushBeat(64'hB1B1_B1B1_0000_0001, 1);
        bus.req  = 4'b0011;
        bus.lock = 4'b0001;
        for (int c = 1; c <= 18; c++) begin
            step();
            if (c == 16) begin
                chk("t3 forced release busy", 64'(bus.busy), 64'h0);
                chk("t3 forced release gnt", 64'(bus.gnt), 64'h0);
            end
            if (c == 17) chk("t3 next grant", 64'(bus.gnt), 64'h2);
        end
        bus.req  = 4'b0000;
        bus.lock = 4'b0000;

        // 4: owner drops request after grant
        setW(2, 64'h2222_0000_0000_0004);
        bus.req = 4'b0100;
        expGnt.push_back(2);
        step();
        chk("t4 gnt", 64'(bus.gnt), 64'h4);
        bus.req = 4'b0000;
        step();
        chk("t4 busy", 64'(bus.busy), 64'h0);
        chk("t4 gnt released", 64'(bus.gnt), 64'h0);
        chk("t4 no q_valid", 64'(bus.q_valid), 64'h0);
        chk("t4 q unchanged", bus.q, 64'hB1B1_B1B1_0000_0001);
        step();
        chk("t4 idle", 64'(bus.busy), 64'h0);

        // 5: reset during locked burst
        setW(0, 64'h5555_5555_5555_5555);
        bus.req  = 4'b0001;
        bus.lock = 4'b0001;
        expGnt.push_back(0);
        pushBeat(64'h5555_5555_5555_5555, 0);
        pushBeat(64'h5555_5555_5555_5555, 0);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        chk("t5 gnt", 64'(bus.gnt), 64'h0);
        chk("t5 q", bus.q, 64'h0);
        chk("t5 owner", 64'(bus.owner), 64'd3);
        chk("t5 q_valid", 64'(bus.q_valid), 64'h0);
        chk("t5 busy", 64'(bus.busy), 64'h0);
        rst      = 1'b0;
        bus.req  = 4'b0100;
        bus.lock = 4'b0000;
        setW(2, 64'h2222_2222_2222_2222);
        expGnt.push_back(2);
        pushBeat(64'h2222_2222_2222_2222, 2);
        step();
        chk("t5 regrant", 64'(bus.gnt), 64'h4);
        step();
        chk("t5 q after", bus.q, 64'h2222_2222_2222_2222);
        bus.req = 4'b0000;
        step();

        // 6: parity of requester 1 data (checked by monitor when enabled)
        setW(1, 64'h1);
        bus.req = 4'b0010;
        expGnt.push_back(1);
        pushBeat(64'h1, 1);
        step();
        step();
`ifdef SHARED_REG_ARB_PARITY_EN
        chk("t6 q_par odd", 64'(bus.q_par), 64'h1);
`endif
        setW(1, 64'h3);
        expGnt.push_back(1);
        pushBeat(64'h3, 1);
        step();
        step();
`ifdef SHARED_REG_ARB_PARITY_EN
        chk("t6 q_par even", 64'(bus.q_par), 64'h0);
`endif
        chk("t6 q", bus.q, 64'h3);
        bus.req = 4'b0000;

        step();
        step();
        step();
        chk("beats outstanding", 64'(expQ.size()), 64'h0);
        chk("grants outstanding", 64'(expGnt.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
